// File: rtl/rect_drawer.sv
`default_nettype none
// ============================================================================
// Module   : rect_drawer
// Brief    : Row-major rectangle rasteriser (filled or outline) emitting one
//            pixel coordinate per valid/ready beat. Optional screen clipping
//            is enabled by defining RECT_DRAWER_CLIP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rect_drawer #(
    parameter int COORD_W  = 11,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] w,
    input  logic [COORD_W-1:0] h,
    input  logic               fill,
    input  logic               pix_ready,
    output logic               pix_valid,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x0_q, x0_d;
    logic [COORD_W-1:0] y0_q, y0_d;
    logic [COORD_W-1:0] w_q, w_d;
    logic [COORD_W-1:0] h_q, h_d;
    logic               fill_q, fill_d;
    logic [COORD_W-1:0] cx_q, cx_d;
    logic [COORD_W-1:0] cy_q, cy_d;

    logic w_in_bounds;
    logic w_advance;
    logic w_last_col;
    logic w_last_row;
    logic w_edge_row;

`ifdef RECT_DRAWER_CLIP_EN
    // Bounds test is done one bit wider so origins near the top of the range never wrap back on screen.
    localparam logic [COORD_W:0] C_SCREEN_W = (COORD_W+1)'(SCREEN_W);
    localparam logic [COORD_W:0] C_SCREEN_H = (COORD_W+1)'(SCREEN_H);
    logic [COORD_W:0] w_x_ext;
    logic [COORD_W:0] w_y_ext;
    assign w_x_ext     = {1'b0, x0_q} + {1'b0, cx_q};
    assign w_y_ext     = {1'b0, y0_q} + {1'b0, cy_q};
    assign w_in_bounds = (w_x_ext < C_SCREEN_W) && (w_y_ext < C_SCREEN_H);
`else
    logic w_unused_screen;
    assign w_unused_screen = (SCREEN_W != 0) ^ (SCREEN_H != 0);
    assign w_in_bounds     = 1'b1;
`endif

    assign busy      = (state_q == S_DRAW);
    assign done      = (state_q == S_DONE);
    assign pix_valid = busy & w_in_bounds;
    assign x         = x0_q + cx_q;
    assign y         = y0_q + cy_q;

    // A clipped pixel is skipped without waiting for the consumer.
    assign w_advance  = busy & (pix_ready | ~w_in_bounds);
    assign w_last_col = (cx_q == w_q - COORD_W'(1));
    assign w_last_row = (cy_q == h_q - COORD_W'(1));
    assign w_edge_row = (cy_q == '0) | w_last_row;

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        fill_d  = fill_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x0_d   = x0;
                    y0_d   = y0;
                    w_d    = w;
                    h_d    = h;
                    fill_d = fill;
                    cx_d   = '0;
                    cy_d   = '0;
                    state_d = ((w == '0) || (h == '0)) ? S_DONE : S_DRAW;
                end
            end
            S_DRAW: begin
                if (w_advance) begin
                    if (w_last_col) begin
                        if (w_last_row) begin
                            state_d = S_DONE;
                        end else begin
                            cx_d = '0;
                            cy_d = cy_q + COORD_W'(1);
                        end
                    end else if (fill_q || w_edge_row) begin
                        cx_d = cx_q + COORD_W'(1);
                    end else begin
                        // Interior outline row: left edge straight to right edge.
                        cx_d = w_q - COORD_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            fill_q  <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            fill_q  <= fill_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
        end
    end

endmodule
`default_nettype wire
